// File: rtl/spi_host_master.sv
// Byte-oriented SPI mode-0 master for the guest control bus (SCK/DI/DO plus CONF_DATA0, SS2, SS3 selects).
// Define SPI_SS4_EN to add a fourth select (spi_ss4_n) and widen sel_val to 4 bits.
module spi_host_master #(
    parameter int CLKDIV = 4
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       sel_wr,
`ifdef SPI_SS4_EN
    input  logic [3:0] sel_val,
`else
    input  logic [2:0] sel_val,
`endif
    input  logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       busy,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       spi_sck,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       spi_conf_n,
    output logic       spi_ss2_n,
    output logic       spi_ss3_n
`ifdef SPI_SS4_EN
    ,
    output logic       spi_ss4_n
`endif
);

`ifdef SPI_SS4_EN
    localparam int SEL_W = 4;
`else
    localparam int SEL_W = 3;
`endif

    localparam logic [7:0] DIV_LAST = 8'(CLKDIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [7:0]         div_cnt;
    logic [2:0]         bit_cnt;
    logic [7:0]         tx_shift;
    logic [7:0]         rx_shift;
    logic [SEL_W-1:0]   sel_n;
    logic               phase_done;

    assign phase_done = (div_cnt == DIV_LAST);
    assign busy       = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (tx_req) state_next = LOW;
            LOW:  if (phase_done) state_next = HIGH;
            HIGH: begin
                if (phase_done) begin
                    state_next = (bit_cnt == 3'd0) ? IDLE : LOW;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Phase timer restarts on every state change so each SCK half lasts exactly CLKDIV cycles.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= 8'd0;
        end else if (state == IDLE || state_next != state) begin
            div_cnt <= 8'd0;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt  <= 3'd0;
            tx_shift <= 8'd0;
            rx_shift <= 8'd0;
            rx_data  <= 8'd0;
            rx_valid <= 1'b0;
            spi_sck  <= 1'b0;
            spi_mosi <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_req) begin
                        tx_shift <= {tx_data[6:0], 1'b0};
                        spi_mosi <= tx_data[7];
                        bit_cnt  <= 3'd7;
                    end
                end
                LOW: begin
                    if (phase_done) begin
                        spi_sck  <= 1'b1;
                        rx_shift <= {rx_shift[6:0], spi_miso};
                    end
                end
                HIGH: begin
                    if (phase_done) begin
                        spi_sck <= 1'b0;
                        if (bit_cnt != 3'd0) begin
                            spi_mosi <= tx_shift[7];
                            tx_shift <= {tx_shift[6:0], 1'b0};
                            bit_cnt  <= bit_cnt - 3'd1;
                        end else begin
                            rx_data  <= rx_shift;
                            rx_valid <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Selects are frozen while a byte is on the wire; a write together with tx_req lands on the accept edge.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            sel_n <= '1;
        end else if (state == IDLE && sel_wr) begin
            sel_n <= ~sel_val;
        end
    end

    assign spi_conf_n = sel_n[0];
    assign spi_ss2_n  = sel_n[1];
    assign spi_ss3_n  = sel_n[2];
`ifdef SPI_SS4_EN
    assign spi_ss4_n  = sel_n[3];
`endif

endmodule

// File: tb/tb_spi_host_master.sv
// Randomized self-checking bench for spi_host_master: CLKDIV=4 instance for byte/select/reset cases, CLKDIV=1 for back-to-back.
`timescale 1ns/1ps
module tb_spi_host_master;

`ifdef SPI_SS4_EN
    localparam int SEL_W = 4;
`else
    localparam int SEL_W = 3;
`endif
    localparam int CLKDIV_A = 4;
    localparam logic [SEL_W-1:0] SEL_CONF = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_SS3  = SEL_W'(4);

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n = 1'b0;
    int   cycle_no = 0;
    always @(posedge clk) cycle_no <= cycle_no + 1;

    // main instance signals
    logic             sel_wr = 1'b0;
    logic [SEL_W-1:0] sel_val = '0;
    logic             tx_req = 1'b0;
    logic [7:0]       tx_data = 8'h00;
    logic             busy, rx_valid, spi_sck, spi_mosi, spi_miso;
    logic [7:0]       rx_data;
    logic             conf_n, ss2_n, ss3_n;
    logic [SEL_W-1:0] sel_n_out;

    // fast instance signals
    logic             tx_req_f = 1'b0;
    logic [7:0]       tx_data_f = 8'h00;
    logic             busy_f, rx_valid_f, sck_f, mosi_f, miso_f;
    logic [7:0]       rx_data_f;
    logic             conf_n_f, ss2_n_f, ss3_n_f;
`ifdef SPI_SS4_EN
    logic             ss4_n, ss4_n_f;
    assign sel_n_out = {ss4_n, ss3_n, ss2_n, conf_n};
`else
    assign sel_n_out = {ss3_n, ss2_n, conf_n};
`endif

    spi_host_master #(.CLKDIV(CLKDIV_A)) dut (
        .CLOCK_50(clk), .reset_n(reset_n), .sel_wr(sel_wr), .sel_val(sel_val),
        .tx_req(tx_req), .tx_data(tx_data), .busy(busy), .rx_valid(rx_valid),
        .rx_data(rx_data), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .spi_conf_n(conf_n), .spi_ss2_n(ss2_n), .spi_ss3_n(ss3_n)
`ifdef SPI_SS4_EN
        , .spi_ss4_n(ss4_n)
`endif
    );

    spi_host_master #(.CLKDIV(1)) dut_fast (
        .CLOCK_50(clk), .reset_n(reset_n), .sel_wr(1'b0), .sel_val('0),
        .tx_req(tx_req_f), .tx_data(tx_data_f), .busy(busy_f), .rx_valid(rx_valid_f),
        .rx_data(rx_data_f), .spi_sck(sck_f), .spi_mosi(mosi_f), .spi_miso(miso_f),
        .spi_conf_n(conf_n_f), .spi_ss2_n(ss2_n_f), .spi_ss3_n(ss3_n_f)
`ifdef SPI_SS4_EN
        , .spi_ss4_n(ss4_n_f)
`endif
    );

    // Slave models: MISO bit k is slave_byte[7-k] for the k-th SCK rise since the byte started.
    int         rise_cnt = 0, rise_base = 0, rise_cnt_f = 0, rise_base_f = 0;
    logic [7:0] slave_byte = 8'h00, slave_byte_f = 8'h00;
    logic [7:0] mosi_cap = 8'h00, mosi_cap_f = 8'h00;
    int         idx_a, idx_f;
    always @(posedge spi_sck) begin
        mosi_cap <= {mosi_cap[6:0], spi_mosi};
        rise_cnt <= rise_cnt + 1;
    end
    always @(posedge sck_f) begin
        mosi_cap_f <= {mosi_cap_f[6:0], mosi_f};
        rise_cnt_f <= rise_cnt_f + 1;
    end
    assign idx_a    = rise_cnt - rise_base;
    assign idx_f    = rise_cnt_f - rise_base_f;
    assign spi_miso = (idx_a >= 0 && idx_a < 8) ? slave_byte[3'(7 - idx_a)] : 1'b0;
    assign miso_f   = (idx_f >= 0 && idx_f < 8) ? slave_byte_f[3'(7 - idx_f)] : 1'b0;

    // checking
    int checks = 0, failures = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // scoreboard: every rx_valid of the main instance must match the queued slave byte
    logic [7:0]       exp_q[$];
    int               n_exp = 0, rx_pulses = 0;
    logic [SEL_W-1:0] sel_model = '0;
    always @(negedge clk) begin
        if (reset_n && rx_valid) begin
            rx_pulses++;
            if (exp_q.size() > 0) check("rx_data", rx_data, exp_q.pop_front());
        end
    end

    task automatic check_selects(input string tag);
        logic [SEL_W-1:0] exp_n;
        exp_n = ~sel_model;
        check(tag, sel_n_out, exp_n);
    endtask

    // op: 0 plain, 1 sel_wr during busy, 2 tx_req during busy, 3 reset in 4th HIGH phase
    task automatic run_xfer(input logic [7:0] tx, input logic [7:0] sb,
                            input logic do_sel, input logic [SEL_W-1:0] sel, input int op);
        int   cyc, first_hi;
        logic aborted;
        cyc = 0;
        while (busy && cyc < 1000) begin @(negedge clk); cyc++; end
        rise_base  = rise_cnt;
        slave_byte = sb;
        tx_data = tx; tx_req = 1'b1; sel_wr = do_sel; sel_val = sel;
        @(negedge clk);
        tx_req = 1'b0; sel_wr = 1'b0;
        if (do_sel) sel_model = sel;
        if (op != 3) begin exp_q.push_back(sb); n_exp++; end
        check("busy_start", busy, 1);
        cyc = 0; first_hi = -1; aborted = 1'b0;
        while (busy && cyc < 5000) begin
            if (spi_sck && first_hi < 0) first_hi = cyc;
            if (op == 1 && cyc == 10) begin sel_wr = 1'b1; sel_val = SEL_SS3; end
            if (op == 1 && cyc == 11) sel_wr = 1'b0;
            if (op == 1 && cyc == 40) check_selects("sel_locked_mid");
            if (op == 2 && cyc == 20) begin tx_req = 1'b1; tx_data = 8'h55; end
            if (op == 2 && cyc == 21) tx_req = 1'b0;
            if (op == 3 && cyc == 29) begin reset_n = 1'b0; aborted = 1'b1; break; end
            @(negedge clk);
            cyc++;
        end
        if (aborted) begin
            #1;
            check("abort_sck", spi_sck, 0);
            check("abort_mosi", spi_mosi, 0);
            check("abort_busy", busy, 0);
            check("abort_rx_valid", rx_valid, 0);
            check("abort_rx_data", rx_data, 0);
            sel_model = '0;
            check_selects("abort_selects");
            repeat (2) @(negedge clk);
            reset_n = 1'b1;
            repeat (3) @(negedge clk);
            check("abort_stays_idle", busy, 0);
        end else begin
            check("busy_len", cyc, 16 * CLKDIV_A);
            check("first_rise", first_hi, CLKDIV_A);
            check("rx_valid_first_idle", rx_valid, 1);
            check("sck_idle_low", spi_sck, 0);
            check("mosi_bits", mosi_cap, tx);
            check_selects("selects_held");
            @(negedge clk);
            check("rx_valid_single", rx_valid, 0);
            if (op == 2) begin
                repeat (3) @(negedge clk);
                check("no_extra_xfer", busy, 0);
            end
            if (op == 1) begin
                sel_wr = 1'b1; sel_val = SEL_SS3;
                @(negedge clk);
                sel_wr = 1'b0;
                sel_model = SEL_SS3;
                check("ss3_n_after", ss3_n, 0);
                check("conf_n_after", conf_n, 1);
            end
        end
    endtask

    initial begin
        int               t1, t2, cyc;
        logic [SEL_W-1:0] rsel;
        // reset values
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_sck", spi_sck, 0);
        check("rst_mosi", spi_mosi, 0);
        check("rst_busy", busy, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check_selects("rst_selects");

        // basic byte: CONF_DATA0, 0xA5 out, 0x3C back
        run_xfer(8'hA5, 8'h3C, 1'b1, SEL_CONF, 0);
        check("conf_n_basic", conf_n, 0);

        // select protection and ignored request
        run_xfer(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0, '0, 1);
        run_xfer(8'hC6, 8'($urandom_range(0, 255)), 1'b0, '0, 2);

        // randomized bytes and selects
        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 3))
                0:       rsel = SEL_W'(0);
                1:       rsel = SEL_W'(1);
                2:       rsel = SEL_W'(2);
                default: rsel = SEL_W'(4);
            endcase
            run_xfer(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                     1'($urandom_range(0, 1)), rsel, 0);
        end

        // reset mid-byte, then a normal transfer
        run_xfer(8'hF0, 8'h0F, 1'b1, SEL_CONF, 3);
        run_xfer(8'h81, 8'h7E, 1'b1, SEL_CONF, 0);

`ifdef SPI_SS4_EN
        run_xfer(8'h3A, 8'hB2, 1'b1, 4'b1000, 0);
        check("ss4_only", sel_n_out, 4'b0111);
`endif

        // back-to-back at CLKDIV=1 with tx_req held
        rise_base_f = rise_cnt_f; slave_byte_f = 8'h5A;
        tx_data_f = 8'h01; tx_req_f = 1'b1;
        @(negedge clk);
        cyc = 0;
        while (!rx_valid_f && cyc < 200) begin @(negedge clk); cyc++; end
        check("b2b_rx1_seen", rx_valid_f, 1);
        t1 = cycle_no;
        check("b2b_rx1_data", rx_data_f, 8'h5A);
        check("b2b_mosi1", mosi_cap_f, 8'h01);
        rise_base_f = rise_cnt_f; slave_byte_f = 8'hC3; tx_data_f = 8'hFF;
        @(negedge clk);
        tx_req_f = 1'b0;
        check("b2b_reaccept", busy_f, 1);
        cyc = 0;
        while (!rx_valid_f && cyc < 200) begin @(negedge clk); cyc++; end
        check("b2b_rx2_seen", rx_valid_f, 1);
        t2 = cycle_no;
        check("b2b_gap", t2 - t1, 17);
        check("b2b_rx2_data", rx_data_f, 8'hC3);
        check("b2b_mosi2", mosi_cap_f, 8'hFF);
        repeat (3) @(negedge clk);
        check("b2b_idle_after", busy_f, 0);

        repeat (4) @(negedge clk);
        check("rx_pulse_count", rx_pulses, n_exp);
        check("exp_q_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_host_master.md
# spi_host_master

Byte-oriented SPI master, mode 0 (CPOL=0, CPHA=0), that drives the guest core's control SPI bus (`SPI_SCK`, `SPI_DI`, `SPI_SS2`, `SPI_SS3`, `CONF_DATA0`) and samples `SPI_DO`. It is the host end of the link the guest's user_io/data_io/OSD slaves already implement. It sits in the board top beside the guest and is fed by the on-board control CPU through a simple request/ack register interface.

## Interface
Parameters:
- `CLKDIV`, 4: SCK half-period in `CLOCK_50` cycles; legal range 1..255.

Ports:
- `CLOCK_50`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `sel_wr`  in  1  one-cycle strobe; load `sel_val` into the select register.
- `sel_val`  in  3  one-hot, active-high: [0]=CONF_DATA0, [1]=SS2, [2]=SS3; 0 = deselect all.
- `tx_req`  in  1  start a byte transfer; accepted when `busy`=0.
- `tx_data`  in  8  byte to send, MSB first; captured on acceptance.
- `busy`  out  1  transfer in progress.
- `rx_valid`  out  1  one-cycle pulse; `rx_data` holds the received byte.
- `rx_data`  out  8  last received byte; held until the next `rx_valid`.
- `spi_sck`  out  1  to guest `SPI_SCK`.
- `spi_mosi`  out  1  to guest `SPI_DI`.
- `spi_miso`  in  1  from guest `SPI_DO`.
- `spi_conf_n`, `spi_ss2_n`, `spi_ss3_n`  out  1 each  active-low selects.

## Operation
- Select register: `sel_wr` loads it when `busy`=0. When `busy`=1, `sel_wr` is ignored and the selects stay stable for the whole byte. Selects are registered outputs, with `_n` = ~register bit.
- If `sel_wr` and `tx_req` occur together while idle, the new select takes effect on the same edge the transfer is accepted. The select therefore leads the first SCK rise by `CLKDIV` cycles.
- A transfer with all selects deasserted still runs. Only the slave's behaviour is undefined.
- FSM states: IDLE, LOW, HIGH.
  - IDLE -> LOW on `tx_req`. This loads the shift register with `tx_data`, sets bit counter = 7, drives `spi_mosi`=`tx_data[7]`, and sets `busy`=1.
  - LOW, after `CLKDIV` cycles -> HIGH. `spi_sck` rises and `spi_miso` is shifted into rx LSB on that same edge.
  - HIGH, after `CLKDIV` cycles: if counter ≠ 0 -> LOW, with `spi_sck` falling, the next MOSI bit presented and counter decremented. If counter = 0 -> IDLE, with `spi_sck` low, `rx_data` loaded, `rx_valid`=1 for one cycle and `busy`=0.
- `spi_mosi` holds the last sent bit in IDLE. Slaves ignore it with SCK low.
- A divider counter (8 bits) counts phase cycles and is reset on every state change.

## Timing
- Reset values: `spi_sck`=0, `spi_mosi`=0, all `_n` selects=1, `busy`=0, `rx_valid`=0, `rx_data`=0x00, FSM=IDLE. Reset mid-transfer aborts immediately with no `rx_valid`.
- `busy` is high for exactly 16×`CLKDIV` cycles, starting the cycle after acceptance.
- `rx_valid` is asserted in the first cycle `busy` is 0.
- Back-to-back: if `tx_req` is held, the next byte is accepted in that cycle. The gap between bytes is one SCK-low period plus one clock cycle.
- `tx_req` while `busy`=1 is ignored; it is not queued.
- SCK frequency = 50 MHz / (2×`CLKDIV`). With `CLKDIV`=1, SCK is 25 MHz and each phase lasts one cycle.

## Configuration
- `SPI_SS4_EN` defined:
  - `sel_val` widens to 4 bits, with [3] = SS4.
  - Output `spi_ss4_n` is added to drive the guest's direct-upload select.
  - Reset value of `spi_ss4_n` is 1.
- `SPI_SS4_EN` undefined: 3-bit `sel_val`, and no `spi_ss4_n` port.

## Test plan
- Reset mid-byte: assert `reset_n`=0 during the 4th HIGH phase -> all outputs return to reset values at once. No `rx_valid` is produced and the next transfer works normally.
- Basic byte, `CLKDIV`=4, select CONF_DATA0, send 0xA5 with slave model returning 0x3C:
  - MOSI sampled on rising edges reads 1,0,1,0,0,1,0,1.
  - `rx_data`=0x3C with a single `rx_valid` pulse.
  - `busy` high for exactly 64 cycles.
- Back-to-back: hold `tx_req` with 0x01 then 0xFF at `CLKDIV`=1 -> two `rx_valid` pulses, 17 cycles apart.
- Select protection: `sel_wr` with `sel_val`=3'b100 issued while `busy` -> `spi_conf_n` stays 0 and `spi_ss3_n` stays 1. The same write issued after `busy` drops -> `spi_ss3_n`=0, `spi_conf_n`=1.
- Ignored request: pulse `tx_req` at 0x55 mid-transfer -> no extra transfer and no change to the shifted data.
- `SPI_SS4_EN` build: `sel_val`=4'b1000 -> only `spi_ss4_n`=0. Without the macro, a 3-bit bench compiles and no `spi_ss4_n` port exists.
